fpu_issue_rob: RTL
==================

Name: fpu_issue_rob

Overview:
- Core-side initiator for the FPU wrapper's request/result protocol.
- Accepts FP operations from the integer pipeline with a valid/ready handshake and forwards them to the FPU input port, tagging each with a reorder-slot tag.
- The FPU result port is a single-cycle pulse with no backpressure. This block captures every result into its slot and returns results to the core in issue order, under valid/ready.
- Handles flush via an epoch bit so that late results from the old epoch are discarded.

Parameters:
- Width, 64, FP operand/result width.
- Depth, 4, reorder slots; power of two, ≥2.
- IdWidth, 5, core-side destination ID width (e.g. rd).
- TagWidth, $clog2(Depth)+1, FPU tag width as {epoch, slot}; derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all in-flight ops
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  request accepted this cycle
- req_operands_i  in  3×Width  operands a,b,c
- req_rnd_mode_i  in  fpnew_pkg::roundmode_e  rounding mode
- req_op_i  in  fpnew_pkg::operation_e  operation
- req_op_mod_i  in  1  op modifier
- req_src_fmt_i / req_dst_fmt_i  in  fpnew_pkg::fp_format_e  formats
- req_int_fmt_i  in  fpnew_pkg::int_format_e  integer format
- req_id_i  in  IdWidth  core destination ID
- rsp_valid_o  out  1  in-order result valid
- rsp_ready_i  in  1  core accepts result
- rsp_result_o  out  Width  result
- rsp_status_o  out  fpnew_pkg::status_t  NV/DZ/OF/UF/NX
- rsp_id_o  out  IdWidth  ID of the returned op
- fpu_in_valid_o  out  1  to FPU in_valid_i
- fpu_in_ready_i  in  1  from FPU in_ready_o
- fpu_operands_o, fpu_rnd_mode_o, fpu_op_o, fpu_op_mod_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o  out  as req_*  pass-through
- fpu_vectorial_op_o  out  1  tied 0
- fpu_tag_o  out  TagWidth  {epoch, tail slot}
- fpu_flush_o  out  1  equals flush_i
- fpu_out_valid_i  in  1  result pulse
- fpu_out_ready_o  out  1  tied 1
- fpu_result_i  in  Width  FPU result
- fpu_status_i  in  fpnew_pkg::status_t  FPU status flags
- fpu_tag_i  in  TagWidth  returned tag
- busy_o  out  1  any slot allocated
- err_o  out  1  sticky protocol error

Behaviour:
- State:
  - head/tail pointers, log2(Depth) bits, wrapping modulo Depth.
  - count, 0..Depth.
  - epoch bit.
  - Per slot: alloc, done, id, result, status.
- Reset (async): all alloc/done=0, head=tail=count=0, epoch=0, err_o=0. Hence rsp_valid_o=0, req_ready_o=0 while count logic is held in reset, busy_o=0.
- Issue:
  - req_ready_o = fpu_in_ready_i & (count<Depth) & !flush_i.
  - fpu_in_valid_o = req_valid_i & (count<Depth) & !flush_i.
  - Request fields pass combinationally to fpu_*; zero added latency.
  - On req_valid_i&req_ready_o: slot[tail] alloc=1, done=0, id=req_id_i; tail++.
- Completion:
  - On fpu_out_valid_i, decode s=fpu_tag_i[slot], e=fpu_tag_i[MSB].
  - e≠epoch: drop silently.
  - e==epoch & alloc[s] & !done[s]: store result/status, done[s]=1.
  - e==epoch & (!alloc[s] | done[s]): drop, err_o←1 (sticky until reset).
- Retire:
  - rsp_valid_o = alloc[head]&done[head]; rsp_* driven from slot[head].
  - On rsp_valid_o&rsp_ready_i: alloc[head]=done[head]=0, head++.
  - rsp_* must hold stable while rsp_valid_o&!rsp_ready_i.
- Simultaneous events:
  - Issue, completion and retire in the same cycle are all legal: count += issue − retire.
  - Completion into the head slot becomes visible on rsp_valid_o the following cycle; no bypass.
  - Issue into a slot freed by retire in the same cycle is impossible, because full blocks issue.
- Flush (flush_i=1 in a cycle):
  - Next edge: all alloc/done cleared, head=tail=count=0, epoch toggled.
  - No issue in that cycle; any concurrent retire is void (rsp_valid_o=0 from next cycle).
  - A completion in the flush cycle is discarded.
  - Results tagged with the old epoch arriving later are dropped without error.
- busy_o = (count≠0).

Decomposition:
- fpnew_pkg gains:
  - fpu_rob_entry_t (id, result, status);
  - function rob_tag_width(depth).
- One sub-module, fpu_rob_slots: slot storage plus done/alloc bits with a write port (completion) and a read port (head). The top holds pointers, epoch and handshake logic.

Test Plan:
- Single ADD, id=3: FPU returns tag {0,0} result 0x4008000000000000 after 10 cycles → rsp_valid_o, rsp_id_o=3, same result, status 0; busy_o falls the cycle after retire.
- Issue ids 1,2,3; FPU completes tags 2,0,1 → responses in order 1,2,3; rsp_valid_o only after slot 0 completes.
- Issue 4 ops with no completion → req_ready_o=0 on the 5th; retire one → req_ready_o=1 next cycle.
- Issue 2, flush_i pulse, then FPU returns tags {0,0},{0,1} → both dropped, err_o=0, rsp_valid_o=0; next issue gets tag {1,0}.
- Hold rsp_ready_i=0 for 5 cycles with head done → rsp_* stable; completions to other slots are still captured.
- Result pulse with tag {0,2} when slot 2 is unallocated → dropped, err_o=1 and held.

Source files
------------

// File: rtl/fpnew_pkg.sv
// FPnew type subset used on the core/FPU boundary, plus the reorder-entry type and tag-width helper
// used by fpu_issue_rob.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FNMSUB   = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9,
    F2F      = 4'd10,
    F2I      = 4'd11,
    I2F      = 4'd12,
    CPKAB    = 4'd13,
    CPKCD    = 4'd14
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Entry payload is sized for the widest supported result and ID.
  localparam int unsigned ROB_RESULT_W = 64;
  localparam int unsigned ROB_ID_W     = 5;

  typedef struct packed {
    logic [ROB_ID_W-1:0]     id;
    logic [ROB_RESULT_W-1:0] result;
    status_t                 status;
  } fpu_rob_entry_t;

  function automatic int unsigned rob_tag_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fpu_rob_slots.sv
// Reorder-slot storage: per-slot alloc/done flags and id/result/status payload.
// All writes take effect on the next edge; the head read port is combinational.
module fpu_rob_slots
  import fpnew_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = $clog2(Depth)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_clr,
  input  logic                    i_alloc_vld,
  input  logic [PtrW-1:0]         i_alloc_slot,
  input  logic [ROB_ID_W-1:0]     i_alloc_id,
  input  logic                    i_cpl_vld,
  input  logic [PtrW-1:0]         i_cpl_slot,
  input  logic [ROB_RESULT_W-1:0] i_cpl_result,
  input  status_t                 i_cpl_status,
  input  logic                    i_free_vld,
  input  logic [PtrW-1:0]         i_free_slot,
  input  logic [PtrW-1:0]         i_rd_slot,
  output logic [Depth-1:0]        o_alloc,
  output logic [Depth-1:0]        o_done,
  output fpu_rob_entry_t          o_rd_entry
);

  fpu_rob_entry_t w_entries [Depth];

  for (genvar g = 0; g < Depth; g++) begin : g_slot
    localparam logic [PtrW-1:0] Idx = PtrW'(g);

    logic           r_alloc;
    logic           r_done;
    fpu_rob_entry_t r_entry;

    // Free and alloc never target the same slot in one cycle: a full buffer blocks issue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_alloc <= 1'b0;
        r_done  <= 1'b0;
      end else if (i_clr) begin
        r_alloc <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        if (i_free_vld && i_free_slot == Idx) begin
          r_alloc <= 1'b0;
          r_done  <= 1'b0;
        end
        if (i_alloc_vld && i_alloc_slot == Idx) begin
          r_alloc <= 1'b1;
          r_done  <= 1'b0;
        end
        if (i_cpl_vld && i_cpl_slot == Idx) begin
          r_done <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (i_alloc_vld && i_alloc_slot == Idx) begin
        r_entry.id <= i_alloc_id;
      end
      if (i_cpl_vld && i_cpl_slot == Idx) begin
        r_entry.result <= i_cpl_result;
        r_entry.status <= i_cpl_status;
      end
    end

    assign o_alloc[g]   = r_alloc;
    assign o_done[g]    = r_done;
    assign w_entries[g] = r_entry;
  end

  assign o_rd_entry = w_entries[i_rd_slot];

endmodule

// File: rtl/fpu_issue_rob.sv
// Core-side FPU initiator: tags ops with {epoch, slot}, captures unthrottled FPU result pulses and
// returns them in issue order. Issue is a zero-latency pass-through; rsp_* holds while !rsp_ready_i.
module fpu_issue_rob
  import fpnew_pkg::*;
#(
  parameter  int unsigned Width    = 64,
  parameter  int unsigned Depth    = 4,
  parameter  int unsigned IdWidth  = 5,
  localparam int unsigned TagWidth = rob_tag_width(Depth)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0][Width-1:0]     req_operands_i,
  input  roundmode_e                req_rnd_mode_i,
  input  operation_e                req_op_i,
  input  logic                      req_op_mod_i,
  input  fp_format_e                req_src_fmt_i,
  input  fp_format_e                req_dst_fmt_i,
  input  int_format_e               req_int_fmt_i,
  input  logic [IdWidth-1:0]        req_id_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [Width-1:0]          rsp_result_o,
  output status_t                   rsp_status_o,
  output logic [IdWidth-1:0]        rsp_id_o,
  output logic                      fpu_in_valid_o,
  input  logic                      fpu_in_ready_i,
  output logic [2:0][Width-1:0]     fpu_operands_o,
  output roundmode_e                fpu_rnd_mode_o,
  output operation_e                fpu_op_o,
  output logic                      fpu_op_mod_o,
  output fp_format_e                fpu_src_fmt_o,
  output fp_format_e                fpu_dst_fmt_o,
  output int_format_e               fpu_int_fmt_o,
  output logic                      fpu_vectorial_op_o,
  output logic [TagWidth-1:0]       fpu_tag_o,
  output logic                      fpu_flush_o,
  input  logic                      fpu_out_valid_i,
  output logic                      fpu_out_ready_o,
  input  logic [Width-1:0]          fpu_result_i,
  input  status_t                   fpu_status_i,
  input  logic [TagWidth-1:0]       fpu_tag_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned   PtrW    = $clog2(Depth);
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(Depth);

  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [PtrW:0]   r_count;
  logic            r_epoch;
  logic            r_err;
  logic            r_run;

  logic [Depth-1:0]        w_alloc;
  logic [Depth-1:0]        w_done;
  fpu_rob_entry_t          w_head;
  logic                    w_can_issue;
  logic                    w_issue;
  logic                    w_retire;
  logic [PtrW-1:0]         w_cpl_slot;
  logic                    w_cpl_hit;
  logic                    w_cpl_ok;
  logic                    w_cpl_bad;
  logic [ROB_ID_W-1:0]     w_alloc_id;
  logic [ROB_RESULT_W-1:0] w_cpl_result;

  // r_run keeps the issue port closed until the first edge after reset release.
  assign w_can_issue    = r_run & (r_count != CntFull) & ~flush_i;
  assign req_ready_o    = fpu_in_ready_i & w_can_issue;
  assign fpu_in_valid_o = req_valid_i & w_can_issue;
  assign w_issue        = req_valid_i & req_ready_o;

  assign fpu_operands_o     = req_operands_i;
  assign fpu_rnd_mode_o     = req_rnd_mode_i;
  assign fpu_op_o           = req_op_i;
  assign fpu_op_mod_o       = req_op_mod_i;
  assign fpu_src_fmt_o      = req_src_fmt_i;
  assign fpu_dst_fmt_o      = req_dst_fmt_i;
  assign fpu_int_fmt_o      = req_int_fmt_i;
  assign fpu_vectorial_op_o = 1'b0;
  assign fpu_tag_o          = {r_epoch, r_tail};
  assign fpu_flush_o        = flush_i;
  assign fpu_out_ready_o    = 1'b1;

  // Old-epoch results and anything landing in the flush cycle are dropped without error.
  assign w_cpl_slot = fpu_tag_i[PtrW-1:0];
  assign w_cpl_hit  = fpu_out_valid_i & ~flush_i & (fpu_tag_i[TagWidth-1] == r_epoch);
  assign w_cpl_ok   = w_cpl_hit & w_alloc[w_cpl_slot] & ~w_done[w_cpl_slot];
  assign w_cpl_bad  = w_cpl_hit & ~(w_alloc[w_cpl_slot] & ~w_done[w_cpl_slot]);

  assign rsp_valid_o  = w_alloc[r_head] & w_done[r_head];
  assign w_retire     = rsp_valid_o & rsp_ready_i & ~flush_i;
  assign rsp_result_o = Width'(w_head.result);
  assign rsp_status_o = w_head.status;
  assign rsp_id_o     = IdWidth'(w_head.id);

  assign w_alloc_id   = ROB_ID_W'(req_id_i);
  assign w_cpl_result = ROB_RESULT_W'(fpu_result_i);

  assign busy_o = (r_count != '0);
  assign err_o  = r_err;

  fpu_rob_slots #(
    .Depth (Depth)
  ) u_slots (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_clr        (flush_i),
    .i_alloc_vld  (w_issue),
    .i_alloc_slot (r_tail),
    .i_alloc_id   (w_alloc_id),
    .i_cpl_vld    (w_cpl_ok),
    .i_cpl_slot   (w_cpl_slot),
    .i_cpl_result (w_cpl_result),
    .i_cpl_status (fpu_status_i),
    .i_free_vld   (w_retire),
    .i_free_slot  (r_head),
    .i_rd_slot    (r_head),
    .o_alloc      (w_alloc),
    .o_done       (w_done),
    .o_rd_entry   (w_head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_epoch <= 1'b0;
      r_err   <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_cpl_bad) begin
        r_err <= 1'b1;
      end
      if (flush_i) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_epoch <= ~r_epoch;
      end else begin
        if (w_issue) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_retire) begin
          r_head <= r_head + 1'b1;
        end
        unique case ({w_issue, w_retire})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
